alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// W-bit registered ALU: 8 ops, {n,z,cy,ov} flags, shift-add multiply.
// Latency: 1 cycle for single-cycle ops, W+1 cycles for multiply (accept edge to out_valid).
// Backpressure: accepts only in IDLE; the result and flags hold in DONE until out_ready.
module alu_seq #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   c,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] F,
    output logic [3:0]   flags,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD1 = 3'b000;
    localparam logic [2:0] OP_PASS = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Multiply runs one step per cycle; the counter starts at W and the
    // step taken while it reads 1 is the last one.
    localparam logic [W-1:0] CNT_LOAD = W'(W);
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [W-1:0]   r_f;
    logic [3:0]     r_flags;

    // Shift-add multiplier: multiplicand shifts left, multiplier shifts right.
    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplr;
    logic [W-1:0]   r_cnt;

    // Single-cycle datapath
    logic [W-1:0]   w_b_opnd;
    logic           w_cin;
    logic [W:0]     w_sum;
    logic [W-1:0]   w_f1;
    logic           w_cy1;
    logic           w_ov1;
    logic [3:0]     w_flags1;

    // Multiply step
    logic [2*W-1:0] w_acc_step;
    logic           w_mul_cy;

    assign F     = r_f;
    assign flags = r_flags;

    // Single-cycle result and flags, computed straight from the live inputs;
    // only used at an accepting edge in IDLE.
    always_comb begin
        w_b_opnd = (c == OP_SUB) ? ~b : b;
        w_cin    = (c == OP_ADD1) || (c == OP_SUB);
        w_sum    = {1'b0, a} + {1'b0, w_b_opnd} + {{W{1'b0}}, w_cin};
        w_f1     = '0;
        w_cy1    = 1'b0;
        w_ov1    = 1'b0;
        case (c)
            OP_ADD1, OP_SUB: begin
                w_f1  = w_sum[W-1:0];
                w_cy1 = w_sum[W];
                // Same-sign operands producing a result of the other sign.
                w_ov1 = (a[W-1] == w_b_opnd[W-1]) && (w_sum[W-1] != a[W-1]);
            end
            OP_PASS: w_f1 = a;
            OP_AND:  w_f1 = a & b;
            OP_OR:   w_f1 = a | b;
            OP_XOR:  w_f1 = a ^ b;
            default: w_f1 = '0;
        endcase
        // Reserved opcode reports all-zero flags, z included.
        if (c == OP_RSVD) begin
            w_flags1 = 4'b0000;
        end else begin
            w_flags1 = {w_f1[W-1], (w_f1 == '0), w_cy1, w_ov1};
        end
    end

    // One shift-add step; cy reflects any product bit beyond the low W.
    always_comb begin
        w_acc_step = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
        w_mul_cy   = |w_acc_step[2*W-1:W];
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (c == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; reset wins over every handshake input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, multiply iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f     <= '0;
            r_flags <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (c == OP_MUL) begin
                            r_acc   <= '0;
                            r_mcand <= {{W{1'b0}}, a};
                            r_mplr  <= b;
                            r_cnt   <= CNT_LOAD;
                        end else begin
                            r_f     <= w_f1;
                            r_flags <= w_flags1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc   <= w_acc_step;
                    r_mcand <= {r_mcand[2*W-2:0], 1'b0};
                    r_mplr  <= {1'b0, r_mplr[W-1:1]};
                    r_cnt   <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_f     <= w_acc_step[W-1:0];
                        r_flags <= {w_acc_step[W-1], (w_acc_step[W-1:0] == '0),
                                    w_mul_cy, 1'b0};
                    end
                end
                default: begin
                    // DONE: result and flags hold until and after the handoff.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=6): directed cases plus randomized ops
// compared against an arithmetic reference model, with stalls and a mid-multiply reset.
module tb_alu_seq;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   c;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] F;
    logic [3:0]   flags;
    logic         out_valid;
    logic         out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode table.
    function automatic void model(input int ua, input int ub, input int uc,
                                  output int f, output int fl, output int lat);
        int mask, s, sa, sb, sr, smin, smax;
        int n, z, cy, ov;
        mask = (1 << W) - 1;
        smax = (1 << (W - 1)) - 1;
        smin = -(1 << (W - 1));
        sa = (ua > smax) ? ua - (1 << W) : ua;
        sb = (ub > smax) ? ub - (1 << W) : ub;
        cy = 0; ov = 0; lat = 1; f = 0;
        case (uc)
            0: begin
                s = ua + ub + 1; f = s & mask; cy = (s >> W) & 1;
                sr = sa + sb + 1; ov = (sr > smax || sr < smin) ? 1 : 0;
            end
            1: f = ua;
            2: f = ua & ub;
            3: begin
                s = ua + ((~ub) & mask) + 1; f = s & mask; cy = (s >> W) & 1;
                sr = sa - sb; ov = (sr > smax || sr < smin) ? 1 : 0;
            end
            4: f = ua | ub;
            5: f = ua ^ ub;
            6: begin
                s = ua * ub; f = s & mask; cy = ((s >> W) != 0) ? 1 : 0; lat = W + 1;
            end
            default: f = 0;
        endcase
        n = (f >> (W - 1)) & 1;
        z = (f == 0) ? 1 : 0;
        fl = (uc == 7) ? 0 : ((n << 3) | (z << 2) | (cy << 1) | ov);
    endfunction

    task automatic scramble();
        a        = W'($urandom);
        b        = W'($urandom);
        c        = 3'($urandom);
        in_valid = 1'($urandom);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return (1 << (W - 1)) - 1;
            2:       return 1 << (W - 1);
            3:       return (1 << W) - 1;
            default: return int'($urandom_range(0, (1 << W) - 1));
        endcase
    endfunction

    // Issue one op from a negedge in IDLE; returns at the negedge after handoff.
    task automatic run_op(input int ua, input int ub, input int uc, input int stall);
        int    ef, efl, elat, n;
        bit    rdy_bad;
        string p;
        model(ua, ub, uc, ef, efl, elat);
        p = $sformatf("op%0d a=%0d b=%0d", uc, ua, ub);
        check({p, " in_ready_idle"}, in_ready, 1);
        a = W'(ua); b = W'(ub); c = 3'(uc); in_valid = 1'b1;
        out_ready = 1'($urandom);
        @(negedge clk);
        n = 1;
        rdy_bad = 1'b0;
        while (out_valid !== 1'b1 && n < 4 * W + 8) begin
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            scramble();
            out_ready = 1'($urandom);
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        check({p, " latency"}, n, elat);
        check({p, " F"}, F, ef);
        check({p, " flags"}, flags, efl);
        check({p, " in_ready_busy"}, rdy_bad, 0);
        check({p, " in_ready_done"}, in_ready, 0);
        for (int k = 0; k < stall; k++) begin
            scramble();
            @(negedge clk);
            check({p, " hold F"}, F, ef);
            check({p, " hold flags"}, flags, efl);
            check({p, " hold out_valid"}, out_valid, 1);
            check({p, " hold in_ready"}, in_ready, 0);
        end
        scramble();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({p, " post out_valid"}, out_valid, 0);
        check({p, " post in_ready"}, in_ready, 1);
        check({p, " post F"}, F, ef);
        check({p, " post flags"}, flags, efl);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset F", F, 0);
        check("reset flags", flags, 0);
        rst_n = 1'b1;

        // Directed cases
        run_op(5, 3, 0, 0);
        run_op(31, 0, 0, 0);
        run_op(3, 5, 3, 0);
        run_op(5, 5, 3, 0);
        run_op(32, 1, 3, 0);
        run_op(32'h2C, 32'h1A, 2, 0);
        run_op(32'h2C, 32'h1A, 4, 0);
        run_op(32'h2C, 32'h1A, 5, 0);
        run_op(32'h15, 32'h3F, 1, 0);
        run_op(7, 9, 6, 5);
        run_op(8, 8, 6, 0);
        run_op(63, 63, 6, 1);
        run_op(42, 17, 7, 2);
        run_op(5, 3, 0, 5);

        // Reset on cycle 3 of a multiply
        a = W'(7); b = W'(9); c = 3'(6); in_valid = 1'b1;
        @(negedge clk);
        scramble();
        @(negedge clk);
        scramble();
        @(negedge clk);
        rst_n = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("midmul reset in_ready", in_ready, 1);
        check("midmul reset out_valid", out_valid, 0);
        check("midmul reset F", F, 0);
        check("midmul reset flags", flags, 0);
        run_op(1, 1, 0, 0);

        // Randomized ops
        for (int i = 0; i < 250; i++) begin
            run_op(pick(), pick(), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
